// File: rtl/synth_pkg.sv
// Shared types and default widths for the polyphonic FM synthesizer slice.
package synth_pkg;

    localparam int PHASE_W_DEF  = 24;
    localparam int SAMPLE_W_DEF = 14;
    localparam int LUT_AW_DEF   = 10;

    typedef enum logic [2:0] {
        IDLE,
        MOD,
        CAR,
        ACC,
        HOLD
    } synth_state_t;

endpackage

// File: rtl/poly_fm_synth_if.sv
// Output sample stream: registered sample with a valid/ready handshake.
interface poly_fm_synth_if
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
);

    logic signed [SAMPLE_W-1:0] sample;
    logic                       sample_valid;
    logic                       sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sine_lut.sv
// Full-cycle sine ROM with a registered read port (one cycle of latency).
module sine_lut
    import synth_pkg::*;
#(
    parameter int LUT_AW   = LUT_AW_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                       clk,
    input  logic [LUT_AW-1:0]          addr,
    output logic signed [SAMPLE_W-1:0] data
);

    // Table contents are folded at elaboration; the argument is reduced to [-pi, pi] so the series converges fast.
    function automatic int sine_entry(input int k);
        real pi;
        real x;
        real term;
        real sum;
        real scaled;
        pi = 3.14159265358979323846;
        x  = 2.0 * pi * k / (2.0 ** LUT_AW);
        if (x > pi) begin
            x = x - 2.0 * pi;
        end
        term = x;
        sum  = x;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / ((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        scaled = ((2.0 ** (SAMPLE_W - 1)) - 1.0) * sum;
        if (scaled >= 0.0) begin
            return $rtoi(scaled + 0.5);
        end
        return -$rtoi(0.5 - scaled);
    endfunction

    logic signed [SAMPLE_W-1:0] rom [2**LUT_AW];

    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
        localparam int ENTRY = sine_entry(k);
        assign rom[k] = SAMPLE_W'(ENTRY);
    end

    always_ff @(posedge clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/poly_fm_synth.sv
// Time-multiplexed polyphonic two-operator FM synthesizer: each voice spends MOD, CAR and
// ACC cycles on one shared sine table, and the saturated mix is held until the consumer takes it.
module poly_fm_synth
    import synth_pkg::*;
#(
    parameter int N_VOICES = 4,
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int LUT_AW   = LUT_AW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_VOICES*PHASE_W-1:0] carrier_fcws,
    input  logic [N_VOICES*PHASE_W-1:0] mod_fcws,
    input  logic [4:0]                  mod_shift,
    input  logic [N_VOICES-1:0]         note_en,
    input  logic [2:0]                  mix_shift,
    poly_fm_synth_if.master             out_if
);

    localparam int V_W   = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + 3;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (SAMPLE_W - 1)));

    synth_state_t               state;
    synth_state_t               state_next;
    logic [V_W-1:0]             v;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    contrib;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    acc_shifted;
    logic signed [SAMPLE_W-1:0] sample_sat;
    logic [PHASE_W-1:0]         car_phase [N_VOICES];
    logic [PHASE_W-1:0]         mod_phase [N_VOICES];
    logic [PHASE_W-1:0]         car_fcw_arr [N_VOICES];
    logic [PHASE_W-1:0]         mod_fcw_arr [N_VOICES];
    logic [PHASE_W-1:0]         lut_ext;
    logic [PHASE_W-1:0]         inc;
    logic [LUT_AW-1:0]          lut_addr;
    logic signed [SAMPLE_W-1:0] lut_data;
    logic                       last_voice;
    logic                       handshake;

    for (genvar g = 0; g < N_VOICES; g++) begin : g_unpack
        assign car_fcw_arr[g] = carrier_fcws[g*PHASE_W +: PHASE_W];
        assign mod_fcw_arr[g] = mod_fcws[g*PHASE_W +: PHASE_W];
    end

    sine_lut #(
        .LUT_AW   (LUT_AW),
        .SAMPLE_W (SAMPLE_W)
    ) u_sine_lut (
        .clk  (clk),
        .addr (lut_addr),
        .data (lut_data)
    );

    // The table is read for the modulator in MOD and for the carrier in every other state.
    assign lut_addr   = (state == MOD) ? mod_phase[v][PHASE_W-1 -: LUT_AW]
                                       : car_phase[v][PHASE_W-1 -: LUT_AW];
    assign lut_ext    = PHASE_W'(lut_data);
    assign inc        = car_fcw_arr[v] + (lut_ext << mod_shift);
    assign contrib    = note_en[v] ? ACC_W'(lut_data) : ACC_W'(0);
    assign acc_sum    = acc + contrib;
    assign acc_shifted = acc_sum >>> mix_shift;
    assign last_voice = (int'(v) == N_VOICES - 1);
    assign handshake  = out_if.sample_valid && out_if.sample_ready;

    always_comb begin
        sample_sat = SAMPLE_W'(acc_shifted);
        if (acc_shifted > SAT_MAX) begin
            sample_sat = SAMPLE_W'(SAT_MAX);
        end else if (acc_shifted < SAT_MIN) begin
            sample_sat = SAMPLE_W'(SAT_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = MOD;
            MOD:     state_next = CAR;
            CAR:     state_next = ACC;
            ACC:     state_next = last_voice ? HOLD : MOD;
            HOLD:    if (handshake) state_next = MOD;
            default: state_next = IDLE;
        endcase
    end

    // A disabled voice has its phases parked at zero so re-enabling restarts the note cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            v                   <= '0;
            acc                 <= '0;
            out_if.sample       <= '0;
            out_if.sample_valid <= 1'b0;
            for (int i = 0; i < N_VOICES; i++) begin
                car_phase[i] <= '0;
                mod_phase[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    v   <= '0;
                    acc <= '0;
                end
                CAR: begin
                    if (note_en[v]) begin
                        car_phase[v] <= car_phase[v] + inc;
                        mod_phase[v] <= mod_phase[v] + mod_fcw_arr[v];
                    end else begin
                        car_phase[v] <= '0;
                        mod_phase[v] <= '0;
                    end
                end
                ACC: begin
                    acc <= acc_sum;
                    if (last_voice) begin
                        out_if.sample       <= sample_sat;
                        out_if.sample_valid <= 1'b1;
                    end else begin
                        v <= v + V_W'(1);
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        out_if.sample_valid <= 1'b0;
                        v                   <= '0;
                        acc                 <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
